// File: rtl/tile_256_index_fetch.sv
// Scan-coordinate to palette-index fetch stage for the 256-tile renderer.
// Ports: vga_clk/reset_n, DrawX/DrawY/blank/hs/vs in, scroll_x/scroll_y,
//   map_we/map_waddr/map_wdata (tile map write), rom_addr/rom_data (pixel ROM),
//   index/blank_out/hs_out/vs_out (aligned to index), scroll_err (sticky).
module tile_256_index_fetch #(
   parameter int MAP_W = 40,
   parameter int MAP_H = 30,
   parameter int SCR_W = 640,
   parameter int SCR_H = 480
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   input  logic        hs,
   input  logic        vs,
   input  logic [9:0]  scroll_x,
   input  logic [8:0]  scroll_y,
   input  logic        map_we,
   input  logic [10:0] map_waddr,
   input  logic [7:0]  map_wdata,
   output logic [15:0] rom_addr,
   input  logic [4:0]  rom_data,
   output logic [4:0]  index,
   output logic        blank_out,
   output logic        hs_out,
   output logic        vs_out,
   output logic        scroll_err
);

   localparam int MAP_N = MAP_W * MAP_H;

   logic [7:0]  map_q [MAP_N];

   logic [9:0]  sx_q;
   logic [8:0]  sy_q;
   logic        vs_prev_q;
   logic        err_q;
   logic [10:0] raddr_q, raddr_d;
   logic [3:0]  fx_q, fy_q;
   logic [15:0] rom_addr_q;
   logic [3:0]  bl_q, hs_q, vs_q;
   logic [4:0]  index_q;

   logic        vis, blank_eff, vs_fall, scr_ok;
   logic [10:0] sum_x, sum_y;
   logic [9:0]  px, py;
   logic [4:0]  row;
   logic [5:0]  col;

   assign vis       = (DrawX < 10'(SCR_W)) && (DrawY < 10'(SCR_H));
   assign blank_eff = blank & vis;
   assign vs_fall   = vs_prev_q & ~vs;
   assign scr_ok    = (scroll_x < 10'(SCR_W)) && (scroll_y < 9'(SCR_H));

   // Sum of two in-range values stays below 2*mod, so one subtract wraps it.
   always_comb begin
      sum_x = {1'b0, DrawX} + {1'b0, sx_q};
      sum_y = {1'b0, DrawY} + {2'b0, sy_q};
      px = sum_x[9:0];
      py = sum_y[9:0];
      if (sum_x >= 11'(SCR_W)) px = 10'(sum_x - 11'(SCR_W));
      if (sum_y >= 11'(SCR_H)) py = 10'(sum_y - 11'(SCR_H));
      row = py[8:4];
      col = px[9:4];
      // row*40 as row*32 + row*8; off-screen pixels park on entry 0
      raddr_d = 11'd0;
      if (vis)
         raddr_d = {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         sx_q       <= '0;
         sy_q       <= '0;
         vs_prev_q  <= 1'b1;
         err_q      <= 1'b0;
         raddr_q    <= '0;
         fx_q       <= '0;
         fy_q       <= '0;
         rom_addr_q <= '0;
         bl_q       <= '0;
         hs_q       <= '1;
         vs_q       <= '1;
         index_q    <= '0;
      end else begin
         vs_prev_q <= vs;
         if (vs_fall) begin
            if (scr_ok) begin
               sx_q <= scroll_x;
               sy_q <= scroll_y;
            end else begin
               err_q <= 1'b1;
            end
         end
         raddr_q    <= raddr_d;
         fx_q       <= px[3:0];
         fy_q       <= py[3:0];
         // Read-first: a same-cycle write lands after this read.
         rom_addr_q <= {map_q[raddr_q], fy_q, fx_q};
         bl_q       <= {bl_q[2:0], blank_eff};
         hs_q       <= {hs_q[2:0], hs};
         vs_q       <= {vs_q[2:0], vs};
         index_q    <= bl_q[2] ? rom_data : 5'd0;
      end
   end

   // Tile map is deliberately left out of reset.
   always_ff @(posedge vga_clk) begin
      if (map_we && (map_waddr < 11'(MAP_N)))
         map_q[map_waddr] <= map_wdata;
   end

   assign rom_addr   = rom_addr_q;
   assign index      = index_q;
   assign blank_out  = bl_q[3];
   assign hs_out     = hs_q[3];
   assign vs_out     = vs_q[3];
   assign scroll_err = err_q;

endmodule

// File: tb/tb_tile_256_index_fetch.sv
// Directed bench for tile_256_index_fetch with a registered pixel ROM model.
// Ports: none; drives the DUT and prints one summary line.
module tb_tile_256_index_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY;
   logic        blank, hs, vs;
   logic [9:0]  scroll_x;
   logic [8:0]  scroll_y;
   logic        map_we;
   logic [10:0] map_waddr;
   logic [7:0]  map_wdata;
   logic [15:0] rom_addr;
   logic [4:0]  rom_data = 5'd0;
   logic [4:0]  index;
   logic        blank_out, hs_out, vs_out, scroll_err;
   logic        rom_all1 = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tile_256_index_fetch dut (
      .vga_clk(clk), .reset_n(reset_n),
      .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .hs(hs), .vs(vs),
      .scroll_x(scroll_x), .scroll_y(scroll_y),
      .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .index(index), .blank_out(blank_out),
      .hs_out(hs_out), .vs_out(vs_out),
      .scroll_err(scroll_err)
   );

   function automatic logic [4:0] exp_rom(input logic [15:0] a);
      if (a == 16'h0532) return 5'h11;
      return a[4:0] ^ a[12:8];
   endfunction

   always @(posedge clk)
      rom_data <= rom_all1 ? 5'h1F : exp_rom(rom_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic vs_fall(input logic [9:0] x, input logic [8:0] y);
      scroll_x = x;
      scroll_y = y;
      vs = 1'b1;
      step();
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
   endtask

   // present a pixel, check rom_addr after 2 edges and index after 4
   task automatic pix(input string tag, input logic [9:0] x,
                      input logic [9:0] y, input logic b,
                      input logic [15:0] ea, input logic [4:0] ei);
      DrawX = x;
      DrawY = y;
      blank = b;
      step();
      step();
      chk({tag, "_addr"}, 32'(rom_addr), 32'(ea));
      step();
      step();
      chk({tag, "_idx"}, 32'(index), 32'(ei));
   endtask

   initial begin
      reset_n = 1'b0;
      DrawX = 10'd100; DrawY = 10'd50;
      blank = 1'b1; hs = 1'b0; vs = 1'b0;
      scroll_x = 10'd5; scroll_y = 9'd5;
      map_we = 1'b0; map_waddr = '0; map_wdata = '0;
      step(); step(); step();
      chk("rst_index", 32'(index), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_blank_out", 32'(blank_out), 32'd0);
      chk("rst_hs_out", 32'(hs_out), 32'd1);
      chk("rst_vs_out", 32'(vs_out), 32'd1);
      chk("rst_scroll_err", 32'(scroll_err), 32'd0);

      vs = 1'b1; hs = 1'b1; blank = 1'b0;
      scroll_x = 10'd0; scroll_y = 9'd0;
      reset_n = 1'b1;
      map_we = 1'b1; map_waddr = 11'd1; map_wdata = 8'h05;
      step();
      map_waddr = 11'd0; map_wdata = 8'h33;
      step();
      map_we = 1'b0;

      // first lookup with exact latency checks
      DrawX = 10'd18; DrawY = 10'd3; blank = 1'b1; hs = 1'b0;
      step();
      step();
      chk("lk_addr", 32'(rom_addr), 32'h0532);
      step();
      chk("lk_blank_early", 32'(blank_out), 32'd0);
      step();
      chk("lk_idx", 32'(index), 32'h11);
      chk("lk_blank_out", 32'(blank_out), 32'd1);
      chk("lk_hs_out", 32'(hs_out), 32'd0);
      chk("lk_vs_out", 32'(vs_out), 32'd1);
      hs = 1'b1;

      vs_fall(10'd630, 9'd470);
      pix("wrap", 10'd20, 10'd15, 1'b1, 16'h335A, exp_rom(16'h335A));
      pix("wrap_edge", 10'd10, 10'd10, 1'b1, 16'h3300, exp_rom(16'h3300));
      vs_fall(10'd639, 9'd479);
      pix("wrap_max", 10'd1, 10'd1, 1'b1, 16'h3300, exp_rom(16'h3300));

      vs_fall(10'd16, 9'd0);
      chk("err_clear", 32'(scroll_err), 32'd0);
      pix("scr16", 10'd0, 10'd0, 1'b1, 16'h0500, exp_rom(16'h0500));
      vs_fall(10'd0, 9'd480);
      chk("err_y480", 32'(scroll_err), 32'd1);
      pix("keep_y", 10'd0, 10'd0, 1'b1, 16'h0500, exp_rom(16'h0500));
      vs_fall(10'd700, 9'd0);
      chk("err_x700", 32'(scroll_err), 32'd1);
      scroll_x = 10'd0;
      pix("keep_x", 10'd0, 10'd0, 1'b1, 16'h0500, exp_rom(16'h0500));
      vs_fall(10'd0, 9'd0);
      chk("err_sticky", 32'(scroll_err), 32'd1);
      pix("relatch", 10'd18, 10'd3, 1'b1, 16'h0532, 5'h11);

      rom_all1 = 1'b1;
      pix("blank0", 10'd18, 10'd3, 1'b0, 16'h0532, 5'd0);
      chk("blank0_out", 32'(blank_out), 32'd0);
      DrawX = 10'd700; DrawY = 10'd3; blank = 1'b1;
      step(); step(); step(); step();
      chk("offx_idx", 32'(index), 32'd0);
      DrawX = 10'd18; DrawY = 10'd480;
      step(); step(); step(); step();
      chk("offy_idx", 32'(index), 32'd0);
      pix("ones", 10'd18, 10'd3, 1'b1, 16'h0532, 5'h1F);
      rom_all1 = 1'b0;

      map_we = 1'b1; map_waddr = 11'd1200; map_wdata = 8'hAA;
      step();
      map_we = 1'b0;
      pix("oob_wr0", 10'd0, 10'd0, 1'b1, 16'h3300, exp_rom(16'h3300));
      pix("oob_wr1", 10'd16, 10'd0, 1'b1, 16'h0500, exp_rom(16'h0500));

      // DrawX=16 still presented; switch to col 0 and collide a write
      DrawX = 10'd0;
      step();
      map_we = 1'b1; map_waddr = 11'd0; map_wdata = 8'h07;
      step();
      chk("rfirst_old", 32'(rom_addr), 32'h3300);
      map_we = 1'b0;
      step();
      chk("rfirst_new", 32'(rom_addr), 32'h0700);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tile_256_index_fetch.md
Name: tile_256_index_fetch

Overview:
- Upstream stage of the 256-tile palette lookup: converts VGA scan coordinates into a 5-bit palette index per pixel.
- Holds an internal 40x30 tile map with 8-bit tile ids (256 tile types) and reads an external tile-pixel ROM.
- Applies per-frame hardware scroll with wrap-around, and delays blank/hs/vs so they align with the index it outputs.

Parameters:
- MAP_W, 40, tile columns (16 px each, 640 px)
- MAP_H, 30, tile rows (16 px each, 480 px)
- SCR_W, 640, visible width / horizontal wrap modulus
- SCR_H, 480, visible height / vertical wrap modulus

Ports:
- vga_clk in 1: pixel clock; the only clock
- reset_n in 1: synchronous, active-low reset
- DrawX in 10: current pixel column, 0..639 valid
- DrawY in 10: current pixel row, 0..479 valid
- blank in 1: active-low blanking from VGA controller
- hs in 1: hsync, active low
- vs in 1: vsync, active low
- scroll_x in 10: requested horizontal scroll
- scroll_y in 9: requested vertical scroll
- map_we in 1: tile-map write enable
- map_waddr in 11: map write address = row*40+col
- map_wdata in 8: tile id to write
- rom_addr out 16: {tile_id, fine_y[3:0], fine_x[3:0]}, registered
- rom_data in 5: pixel ROM data, valid exactly 1 cycle after rom_addr
- index out 5: palette index to the palette stage
- blank_out, hs_out, vs_out out 1 each: inputs delayed to align with index
- scroll_err out 1: sticky flag, illegal scroll value requested

Behaviour:
- Clocking and reset: one clock, vga_clk. Reset is synchronous and active-low on reset_n.
- Reset values:
  - index=0, rom_addr=0, blank_out=0, hs_out=1, vs_out=1, scroll_err=0.
  - Latched scroll = (0,0), all pipeline registers cleared.
  - Tile-map contents are NOT cleared.
  - Reset mid-frame takes effect the next edge. Outputs hold reset values while reset_n=0.
- Scroll latch:
  - Trigger is a vs falling edge (vs=0, previous vs=1; the previous-vs register resets to 1).
  - scroll_x<640 and scroll_y<480: both values are latched.
  - Either value out of range: neither is latched, the old pair is kept, and scroll_err is set to 1. It clears only on reset.
  - Scroll changes between vs edges have no effect.
- Pipeline, latency 4 cycles from DrawX/DrawY/blank/hs/vs sampling to index and *_out:
  - E1: px=(DrawX+sx) wrapped to SCR_W by subtracting 640 when the sum is ≥640. py is wrapped to SCR_H the same way. 11-bit intermediate sum; no modulo divider.
    - Registered at E1: map read address (py>>4)*40+(px>>4), fine_x=px[3:0], fine_y=py[3:0].
    - The multiply by 40 is done as shift-add.
  - E2: synchronous map read, so tile_id is registered here. rom_addr={tile_id,fine_y,fine_x} is registered at E2 and drives the ROM.
  - E3: external ROM returns rom_data.
  - E4: index = rom_data when the 4-deep-delayed blank is 1, else 0.
- DrawX≥640 or DrawY≥480 is treated as blank regardless of the blank input, so no map read outside 0..1199.
- Map write port:
  - A write to address <1200 takes effect at the clock edge.
  - map_waddr≥1200: write ignored.
  - Read and write to the same address on the same cycle: read-first, so the old tile_id is returned.
  - Writes are legal in any cycle, including active video.
- The pipeline has no stall and no backpressure; it advances every cycle.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with arbitrary inputs -> index=0, rom_addr=0, blank_out=0, hs_out=vs_out=1, scroll_err=0. Release; first valid index appears 4 cycles after the first sampled pixel.
- Map write and lookup: write map[1]=0x05, scroll=(0,0), then present DrawX=18, DrawY=3, blank=1 -> rom_addr=0x0532 two cycles later. ROM model returns 0x11 -> index=0x11 at cycle 4, with blank_out/hs_out/vs_out matching inputs delayed 4.
- Scroll wrap: request scroll_x=630, scroll_y=470, then vs 1->0. Present DrawX=20, DrawY=15 -> px=10, py=5, map addr 0, rom_addr={map[0],4'h5,4'hA}.
- Illegal scroll: latched (16,0), then request scroll_x=700 and toggle vs -> scroll_err=1 and stays 1. The scroll (16,0) is retained: DrawX=0 reads map col 1.
- Blanking: blank=0 with ROM returning 0x1F -> index=0 at cycle 4. DrawX=700, blank=1 -> index=0 and no map address ≥1200 issued.
- Write edge cases: map_waddr=1200 with wdata=0xAA -> no map entry changes. Simultaneous write map[0]=0x07 and read of addr 0 -> old id used that cycle, 0x07 on the next read.
